wb_regfile: RTL and testbench

Write-back stage and general-purpose register file for the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value (ALU result, load data, or link address), and commits it to a 32×32 register file. Serves the two decode-stage read ports with same-cycle write-through bypass. Also keeps an arithmetic-overflow exception record and a committed-write counter for the debug path.

---
 rtl/wb_regfile_if.sv | 31 +++
 rtl/wb_regfile.sv | 52 +++++
 tb/tb_wb_regfile.sv | 108 ++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB write-back inputs, decode/debug read ports and status outputs of the register file
interface wb_regfile_if #(parameter int WIDTH = 32);
   logic             mem2reg_wr;
   logic             regwr_wr;
   logic             link_wr;
   logic             overflow_wr;
   logic [WIDTH-1:0] alu_result_wr;
   logic [WIDTH-1:0] mem_data_wr;
   logic [4:0]       rw_wr;
   logic [WIDTH-1:0] pc_wr;
   logic [4:0]       ra;
   logic [4:0]       rb;
   logic [WIDTH-1:0] bus_a;
   logic [WIDTH-1:0] bus_b;
   logic [4:0]       dbg_addr;
   logic [WIDTH-1:0] dbg_data;
   logic             ovf_clr;
   logic             ovf_flag;
   logic [WIDTH-1:0] ovf_epc;
   logic [31:0]      wb_count;
   modport master (
      output mem2reg_wr, regwr_wr, link_wr, overflow_wr, alu_result_wr, mem_data_wr,
             rw_wr, pc_wr, ra, rb, dbg_addr, ovf_clr,
      input  bus_a, bus_b, dbg_data, ovf_flag, ovf_epc, wb_count
   );
   modport slave (
      input  mem2reg_wr, regwr_wr, link_wr, overflow_wr, alu_result_wr, mem_data_wr,
             rw_wr, pc_wr, ra, rb, dbg_addr, ovf_clr,
      output bus_a, bus_b, dbg_data, ovf_flag, ovf_epc, wb_count
   );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32x32 register file with write-through bypass, overflow record and write counter
module wb_regfile #(
   parameter int WIDTH       = 32,
   parameter int LINK_OFFSET = 8
) (
   input logic        clk,
   input logic        rst_n,
   wb_regfile_if.slave bus
);
   logic [WIDTH-1:0] regs_q [0:31];
   logic [WIDTH-1:0] wdata;
   logic             we;
   logic             cap;
   logic             flag_q, flag_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [31:0]      cnt_q, cnt_d;
   // write-back value select, commit enable and next-state of the status registers
   always_comb begin
      wdata  = bus.link_wr ? bus.pc_wr + WIDTH'(LINK_OFFSET) :
               bus.mem2reg_wr ? bus.mem_data_wr : bus.alu_result_wr;
      we     = bus.regwr_wr & ~bus.overflow_wr & (bus.rw_wr != 5'd0);
      cap    = bus.regwr_wr & bus.overflow_wr;
      flag_d = cap ? 1'b1 : bus.ovf_clr ? 1'b0 : flag_q;
      epc_d  = (cap && (!flag_q || bus.ovf_clr)) ? bus.pc_wr : epc_q;
      cnt_d  = we ? cnt_q + 32'd1 : cnt_q;
   end
   // register file commit; entry 0 is only ever reset, never written
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we) regs_q[bus.rw_wr] <= wdata;
   // overflow record and committed-write counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         flag_q <= 1'b0;
         epc_q  <= '0;
         cnt_q  <= '0;
      end else begin
         flag_q <= flag_d;
         epc_q  <= epc_d;
         cnt_q  <= cnt_d;
      end
   // combinational reads: decode ports see the value being written this cycle, debug port does not
   always_comb begin
      bus.bus_a    = (bus.ra == 5'd0) ? '0 : (we && bus.ra == bus.rw_wr) ? wdata : regs_q[bus.ra];
      bus.bus_b    = (bus.rb == 5'd0) ? '0 : (we && bus.rb == bus.rw_wr) ? wdata : regs_q[bus.rb];
      bus.dbg_data = (bus.dbg_addr == 5'd0) ? '0 : regs_q[bus.dbg_addr];
      bus.ovf_flag = flag_q;
      bus.ovf_epc  = epc_q;
      bus.wb_count = cnt_q;
   end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: table-driven directed checks of wb_regfile plus reset and counter-wrap sequences
module tb_wb_regfile;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   wb_regfile_if bus ();
   wb_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic        regwr, link, m2r, ovf, clr;
      logic [4:0]  rw, ra, rb, dbg;
      logic [31:0] alu, mem, pc;
      logic [31:0] exp_a, exp_b, exp_dbg0, exp_dbg1, exp_cnt, exp_epc;
      logic        exp_flag;
   } vec_t;
   vec_t v [12];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask
   task automatic idle();
      bus.regwr_wr = 0; bus.link_wr = 0; bus.mem2reg_wr = 0; bus.overflow_wr = 0; bus.ovf_clr = 0;
      bus.rw_wr = 0; bus.ra = 0; bus.rb = 0; bus.dbg_addr = 0;
      bus.alu_result_wr = 0; bus.mem_data_wr = 0; bus.pc_wr = 0;
   endtask
   initial begin
      //       regwr link m2r ovf clr  rw  ra  rb  dbg  alu           mem           pc            a             b             dbg0          dbg1          cnt  epc       flag
      v[0]  = '{1, 1, 1, 0, 0, 31, 31,  0, 31, 32'h11,       32'h22,       32'h00400010, 32'h00400018, 32'h0,        32'h0,        32'h00400018, 1, 32'h0,   0};
      v[1]  = '{1, 0, 1, 0, 0,  8,  8, 31,  8, 32'h33,       32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h00400018, 32'h0,        32'hDEADBEEF, 2, 32'h0,   0};
      v[2]  = '{1, 0, 0, 0, 0,  9,  9,  9,  9, 32'hA5A5A5A5, 32'h0,        32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 3, 32'h0,   0};
      v[3]  = '{1, 0, 0, 0, 0,  0,  0,  9,  0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'hA5A5A5A5, 32'h0,        32'h0,        3, 32'h0,   0};
      v[4]  = '{1, 0, 0, 1, 0,  4,  4,  4,  4, 32'h44,       32'h0,        32'h100,      32'h0,        32'h0,        32'h0,        32'h0,        3, 32'h100, 1};
      v[5]  = '{1, 0, 0, 1, 0,  4,  4,  8,  4, 32'h55,       32'h0,        32'h200,      32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        3, 32'h100, 1};
      v[6]  = '{1, 0, 0, 1, 1,  4,  4,  0,  4, 32'h66,       32'h0,        32'h300,      32'h0,        32'h0,        32'h0,        32'h0,        3, 32'h300, 1};
      v[7]  = '{0, 0, 0, 0, 1,  4,  4,  0,  4, 32'h77,       32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        3, 32'h300, 0};
      v[8]  = '{0, 0, 0, 1, 0,  4,  4,  0,  4, 32'h88,       32'h0,        32'h400,      32'h0,        32'h0,        32'h0,        32'h0,        3, 32'h300, 0};
      v[9]  = '{1, 0, 0, 0, 0,  4,  4,  8,  4, 32'h12345678, 32'h0,        32'h0,        32'h12345678, 32'hDEADBEEF, 32'h0,        32'h12345678, 4, 32'h300, 0};
      v[10] = '{0, 0, 0, 0, 0,  4,  4, 31,  4, 32'h999,      32'h0,        32'h0,        32'h12345678, 32'h00400018, 32'h12345678, 32'h12345678, 4, 32'h300, 0};
      v[11] = '{1, 1, 0, 0, 0,  2,  2,  9,  2, 32'h1,        32'h2,        32'hFFFFFFFC, 32'h4,          32'hA5A5A5A5, 32'h0,        32'h4,        5, 32'h300, 0};
      idle();
      #3;
      chk("rst_cnt", bus.wb_count, 0);
      chk("rst_flag", {31'b0, bus.ovf_flag}, 0);
      chk("rst_epc", bus.ovf_epc, 0);
      chk("rst_bus_a", bus.bus_a, 0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.regwr_wr = v[i].regwr; bus.link_wr = v[i].link; bus.mem2reg_wr = v[i].m2r;
         bus.overflow_wr = v[i].ovf; bus.ovf_clr = v[i].clr; bus.rw_wr = v[i].rw;
         bus.ra = v[i].ra; bus.rb = v[i].rb; bus.dbg_addr = v[i].dbg;
         bus.alu_result_wr = v[i].alu; bus.mem_data_wr = v[i].mem; bus.pc_wr = v[i].pc;
         #1;
         chk($sformatf("v%0d_bus_a", i), bus.bus_a, v[i].exp_a);
         chk($sformatf("v%0d_bus_b", i), bus.bus_b, v[i].exp_b);
         chk($sformatf("v%0d_dbg_pre", i), bus.dbg_data, v[i].exp_dbg0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_dbg_post", i), bus.dbg_data, v[i].exp_dbg1);
         chk($sformatf("v%0d_cnt", i), bus.wb_count, v[i].exp_cnt);
         chk($sformatf("v%0d_flag", i), {31'b0, bus.ovf_flag}, {31'b0, v[i].exp_flag});
         chk($sformatf("v%0d_epc", i), bus.ovf_epc, v[i].exp_epc);
      end
      // mid-cycle reset after committing r5
      @(negedge clk);
      idle();
      bus.regwr_wr = 1; bus.rw_wr = 5; bus.alu_result_wr = 32'h1234;
      @(posedge clk);
      #1;
      bus.regwr_wr = 0; bus.ra = 5; bus.dbg_addr = 5;
      #1;
      chk("r5_written", bus.bus_a, 32'h1234);
      chk("cnt_before_rst", bus.wb_count, 6);
      rst_n = 0;
      #1;
      chk("midrst_bus_a", bus.bus_a, 0);
      chk("midrst_dbg", bus.dbg_data, 0);
      chk("midrst_cnt", bus.wb_count, 0);
      chk("midrst_flag", {31'b0, bus.ovf_flag}, 0);
      chk("midrst_epc", bus.ovf_epc, 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      chk("postrst_r5", bus.dbg_data, 0);
      chk("postrst_bus_a", bus.bus_a, 0);
      // counter wrap
      @(negedge clk);
      force dut.cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.cnt_q;
      #1;
      chk("cnt_preload", bus.wb_count, 32'hFFFFFFFF);
      bus.regwr_wr = 1; bus.rw_wr = 3; bus.alu_result_wr = 32'h7; bus.dbg_addr = 3;
      @(posedge clk);
      #1;
      chk("cnt_wrap", bus.wb_count, 0);
      chk("wrap_r3", bus.dbg_data, 32'h7);
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
